fa4_prog_mem: RTL and testbench
===============================

# fa4_prog_mem

Program-memory responder for the FA4 CPU: it serves the controller's instruction-fetch requests, returning one or two 4-bit nibbles per request (FETCH1/FETCH2 for two-nibble instructions). It also accepts program words over a separate load port so a bench or boot loader can fill the store. It sits between the controller's fetch interface and the program source, and is the answering end of every fetch the controller issues.

## Interface
- ADDR_W, 4, address width; depth = 2**ADDR_W words
- DATA_W, 4, word (nibble) width
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and the memory array
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request accepted when high with req_valid
- req_addr  in  ADDR_W  fetch address (PC)
- req_two  in  1  1 = return words at req_addr and req_addr+1; 0 = one word
- resp_valid  out  1  resp_data valid
- resp_ready  in  1  consumer takes resp_data when high with resp_valid
- resp_data  out  DATA_W  fetched word
- resp_last  out  1  marks final word of the current request
- ld_valid  in  1  program-load write present
- ld_ready  out  1  load accepted when high with ld_valid
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, READ, RESP1, RESP2.
- IDLE: ld_ready=1; req_ready = ~ld_valid (load has priority when both present).
  - ld_valid: mem[ld_addr] <= ld_data at that edge; stay IDLE.
  - req_valid & ~ld_valid: latch req_addr into addr_q, req_two into two_q; go READ.
- READ: data_q <= mem[addr_q]; go RESP1. No handshakes accepted (req_ready=ld_ready=0).
- RESP1: resp_valid=1, resp_data=data_q, resp_last=~two_q. On resp_ready: if two_q then data_q <= mem[addr_q+1] and go RESP2, else go IDLE. Hold outputs stable while resp_ready=0.
- RESP2: resp_valid=1, resp_data=data_q, resp_last=1. On resp_ready go IDLE.
- Address arithmetic modulo 2**ADDR_W: addr_q+1 wraps (address 15 -> 0 at ADDR_W=4).
- Loads never accepted outside IDLE, so memory is stable during a response; no write/read collision possible.
- Read data is taken from the array at READ/RESP1-advance, so a load accepted the cycle before a request is visible to that request.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_data=0, resp_last=0, busy=0, req_ready=1 (when ld_valid=0), ld_ready=1, every mem word=0, addr_q=0, data_q=0.
- Reset mid-response: outputs drop to reset values asynchronously; in-flight request discarded, no further beat.
- Request accepted at edge N -> READ during N+1 -> resp_valid high from cycle N+2.
- Second word (req_two=1) valid the cycle after the first beat's handshake; zero-bubble beat-to-beat when resp_ready held high.
- Back-to-back: single-word request with resp_ready=1 costs 3 cycles (IDLE, READ, RESP1); next request accepted in the following IDLE cycle.
- Load: 1 cycle, written at acceptance edge; repeated loads every cycle allowed in IDLE.
- req_ready and ld_ready are combinational from state and ld_valid only; never from resp_ready.

## Structure
- fa4_pkg: state enum (IDLE, READ, RESP1, RESP2), default ADDR_W/DATA_W constants, shared with the controller's fetch side.
- Sub-module fa4_mem_array: 2**ADDR_W x DATA_W register array, one write port, two asynchronous read ports (addr, addr+1), async-reset-to-zero. FSM and handshakes in fa4_prog_mem top.

## Test plan
- Reset then load mem[3]=4'hA, request addr 3, req_two=0, resp_ready=1 -> resp_valid at accept+2, resp_data=4'hA, resp_last=1, busy falls next cycle.
- Load mem[15]=4'h5, mem[0]=4'hC; request addr 15, req_two=1 -> beats 4'h5 (last=0) then 4'hC (last=1), wrap verified.
- Same-cycle ld_valid and req_valid in IDLE -> load written, req_ready=0; request accepted next cycle and returns the newly loaded value.
- Hold resp_ready=0 for 5 cycles during RESP1 of a two-word request -> resp_data/resp_last stable, ld_ready=0, req_ready=0; release -> second beat follows next cycle.
- Assert reset in RESP2 -> resp_valid=0 immediately, all mem words read back 0 on subsequent fetches, state IDLE.
- Random load/fetch mix against a reference array model -> every beat matches model, every accepted request yields exactly 1 or 2 beats per req_two.

Source files
------------

// File: rtl/fa4_pkg.sv
// Shared FA4 fetch-side definitions: fetch FSM states and default bus widths.
// Used by the program memory and by the controller's fetch interface.
package fa4_pkg;

  localparam int unsigned FA4_ADDR_W = 4;
  localparam int unsigned FA4_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RESP1 = 2'd2,
    RESP2 = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fa4_prog_mem_if.sv
// Fetch + program-load bus between the FA4 controller/boot loader (master)
// and the program memory (slave).
//   req_*  : fetch request (valid/ready, address, one-or-two-word flag)
//   resp_* : fetched word stream (valid/ready, data, last-beat marker)
//   ld_*   : program-load write (valid/ready, address, data)
interface fa4_prog_mem_if
  import fa4_pkg::*;
#(
  parameter int unsigned ADDR_W = FA4_ADDR_W,
  parameter int unsigned DATA_W = FA4_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_two;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output req_valid, req_addr, req_two, resp_ready, ld_valid, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_data, resp_last, ld_ready
  );

  modport slave (
    input  req_valid, req_addr, req_two, resp_ready, ld_valid, ld_addr, ld_data,
    output req_ready, resp_valid, resp_data, resp_last, ld_ready
  );

endinterface

// File: rtl/fa4_mem_array.sv
// Program store: 2**ADDR_W x DATA_W register array, async reset to zero.
// Ports:
//   clock, reset  : system clock, async active-high reset
//   we_i          : write enable, waddr_i/wdata_i written at the rising edge
//   raddr_i       : read address
//   rdata_o       : mem[raddr_i]       (combinational)
//   rdata_nxt_o   : mem[raddr_i + 1]   (combinational, address wraps)
module fa4_mem_array
  import fa4_pkg::*;
#(
  parameter int unsigned ADDR_W = FA4_ADDR_W,
  parameter int unsigned DATA_W = FA4_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] rdata_nxt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] raddr_nxt;

  // Modulo-depth increment: the top address wraps to 0
  assign raddr_nxt = raddr_i + ADDR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o     = mem_q[raddr_i];
  assign rdata_nxt_o = mem_q[raddr_nxt];

endmodule

// File: rtl/fa4_prog_mem.sv
// FA4 program-memory responder. Serves one- or two-word fetches from the
// controller and accepts program-load writes while idle (load wins a tie).
// Ports:
//   clock, reset : system clock, async active-high reset (also clears memory)
//   bus          : fa4_prog_mem_if slave (fetch request/response, load port)
//   busy         : high whenever the responder is not IDLE
module fa4_prog_mem
  import fa4_pkg::*;
#(
  parameter int unsigned ADDR_W = FA4_ADDR_W,
  parameter int unsigned DATA_W = FA4_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  fa4_prog_mem_if.slave       bus,
  output logic                busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              two_q, two_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_last_q, resp_last_d;
  logic              busy_q, busy_d;

  logic              mem_we;
  logic              req_rdy;
  logic              ld_rdy;
  logic [DATA_W-1:0] rd_cur;
  logic [DATA_W-1:0] rd_nxt;

  fa4_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock       (clock),
    .reset       (reset),
    .we_i        (mem_we),
    .waddr_i     (bus.ld_addr),
    .wdata_i     (bus.ld_data),
    .raddr_i     (addr_q),
    .rdata_o     (rd_cur),
    .rdata_nxt_o (rd_nxt)
  );

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      two_q        <= 1'b0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      two_q        <= two_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, handshakes and memory-write strobe
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    two_d   = two_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    req_rdy = 1'b0;
    ld_rdy  = 1'b0;

    case (state_q)
      IDLE: begin
        ld_rdy  = 1'b1;
        req_rdy = ~bus.ld_valid;
        if (bus.ld_valid) begin
          mem_we = 1'b1;
        end else if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          two_d   = bus.req_two;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rd_cur;
        state_d = RESP1;
      end
      RESP1: begin
        if (bus.resp_ready) begin
          if (two_q) begin
            data_d  = rd_nxt;
            state_d = RESP2;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESP2: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response flags are precomputed from the next state so they are flops
    resp_valid_d = (state_d == RESP1) || (state_d == RESP2);
    resp_last_d  = (state_d == RESP2) || ((state_d == RESP1) && !two_d);
    busy_d       = (state_d != IDLE);
  end

  assign bus.req_ready  = req_rdy;
  assign bus.ld_ready   = ld_rdy;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_last  = resp_last_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fa4_prog_mem.sv
// Self-checking bench for fa4_prog_mem: directed corner cases, a vector
// table of fetches, and a random load/fetch mix against a reference array.
module tb_fa4_prog_mem;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          two;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  logic clk;
  logic rst;
  logic busy;

  int total = 0;
  int bad   = 0;

  beat_t         sb[$];
  logic [DW-1:0] model [16];
  vec_t          vt [6];

  fa4_prog_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fa4_prog_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard: every response handshake pops one expected beat
  always @(negedge clk) begin
    if (!rst && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got data %0h last %0b expected no beat",
                 bus.resp_data, bus.resp_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", 32'(bus.resp_data), 32'(e.data));
        chk("beat_last", 32'(bus.resp_last), 32'(e.last));
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(negedge clk);
    chk("ld_ready", 32'(bus.ld_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    model[a] = d;
  endtask

  task automatic push_exp(input logic two, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    sb.push_back('{data: e0, last: ~two});
    if (two) sb.push_back('{data: e1, last: 1'b1});
  endtask

  // Issue a request and wait (bounded) until all its beats are consumed
  task automatic fetch(input logic [AW-1:0] a, input logic two,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    bit ok;
    push_exp(two, e0, e1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_two   = two;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy == 1'b0) ok = 1;
    end
    if (!ok) begin
      chk("fetch_done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.resp_valid) ok = 1;
    end
    if (!ok) chk("resp_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rn;
    logic          rt;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_two    = 1'b0;
    bus.resp_ready = 1'b1;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    vt[0] = '{addr: 4'd0,  two: 1'b0, e0: 4'hF, e1: 4'h0};
    vt[1] = '{addr: 4'd7,  two: 1'b1, e0: 4'h8, e1: 4'h7};
    vt[2] = '{addr: 4'd15, two: 1'b1, e0: 4'h0, e1: 4'hF};
    vt[3] = '{addr: 4'd9,  two: 1'b0, e0: 4'h6, e1: 4'h0};
    vt[4] = '{addr: 4'd14, two: 1'b1, e0: 4'h1, e1: 4'h0};
    vt[5] = '{addr: 4'd3,  two: 1'b1, e0: 4'hC, e1: 4'hB};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
    chk("rst_resp_last",  32'(bus.resp_last),  32'd0);
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_ld_ready",   32'(bus.ld_ready),   32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-word fetch with latency check
    do_load(4'd3, 4'hA);
    push_exp(1'b0, 4'hA, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_two   = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("lat_read_busy",  32'(busy),           32'd1);
    chk("lat_read_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("lat_resp_data",  32'(bus.resp_data),  32'hA);
    chk("lat_resp_last",  32'(bus.resp_last),  32'd1);
    @(negedge clk);
    chk("lat_busy_fall",  32'(busy),           32'd0);
    chk("lat_valid_fall", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Two-word fetch wrapping 15 -> 0
    do_load(4'd15, 4'h5);
    do_load(4'd0, 4'hC);
    fetch(4'd15, 1'b1, 4'h5, 4'hC);

    // Load and request in the same IDLE cycle: load wins
    push_exp(1'b0, 4'h9, 4'h0);
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 4'd5;
    bus.ld_data   = 4'h9;
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd5;
    bus.req_two   = 1'b0;
    @(negedge clk);
    chk("tie_req_ready", 32'(bus.req_ready), 32'd0);
    chk("tie_ld_ready",  32'(bus.ld_ready),  32'd1);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    model[5] = 4'h9;
    @(negedge clk);
    chk("tie_req_ready_next", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp_valid();
    repeat (2) @(negedge clk);
    chk("tie_drained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure in RESP1 of a two-word request
    do_load(4'd8, 4'h3);
    do_load(4'd9, 4'h6);
    bus.resp_ready = 1'b0;
    push_exp(1'b1, 4'h3, 4'h6);
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd8;
    bus.req_two   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_data",      32'(bus.resp_data),  32'h3);
      chk("hold_last",      32'(bus.resp_last),  32'd0);
      chk("hold_ld_ready",  32'(bus.ld_ready),   32'd0);
      chk("hold_req_ready", 32'(bus.req_ready),  32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_beat2_valid", 32'(bus.resp_valid), 32'd1);
    chk("hold_beat2_data",  32'(bus.resp_data),  32'h6);
    chk("hold_beat2_last",  32'(bus.resp_last),  32'd1);
    @(negedge clk);
    chk("hold_drained", 32'(sb.size()), 32'd0);
    chk("hold_idle",    32'(busy),      32'd0);
    @(posedge clk);
    #1;

    // Vector table over a known memory pattern mem[i] = ~i
    for (int i = 0; i < 16; i++) do_load(AW'(i), ~DW'(i));
    for (int i = 0; i < 6; i++) fetch(vt[i].addr, vt[i].two, vt[i].e0, vt[i].e1);

    // Reset while the second beat is stalled
    bus.resp_ready = 1'b0;
    push_exp(1'b1, model[1], model[2]);
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd1;
    bus.req_two   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp_valid();
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("r2_valid", 32'(bus.resp_valid), 32'd1);
    chk("r2_data",  32'(bus.resp_data),  32'(model[2]));
    chk("r2_last",  32'(bus.resp_last),  32'd1);
    rst = 1'b1;
    #1;
    chk("r2_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("r2_rst_busy",  32'(busy),           32'd0);
    chk("r2_rst_data",  32'(bus.resp_data),  32'd0);
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("r2_req_ready", 32'(bus.req_ready), 32'd1);
    fetch(4'd1, 1'b1, 4'h0, 4'h0);
    fetch(4'd15, 1'b1, 4'h0, 4'h0);
    fetch(4'd7, 1'b0, 4'h0, 4'h0);

    // Random load/fetch mix against the reference array
    for (int n = 0; n < 80; n++) begin
      ra = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        do_load(ra, DW'($urandom_range(0, 15)));
      end else begin
        rt = 1'($urandom_range(0, 1));
        rn = ra + AW'(1);
        fetch(ra, rt, model[ra], model[rn]);
      end
    end

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
